// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_controller
// Description : Gates the processor clock enable for HALT/STEP/RUN/RUN_N host
//               commands, stops on a PC breakpoint, counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
    parameter int PC_W     = 32,
    parameter int CNT_W    = 16,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [CNT_W-1:0]    cmd_count_i,
    input  logic                bp_en_i,
    input  logic [PC_W-1:0]     bp_addr_i,
    input  logic [PC_W-1:0]     pc_i,
    output logic                cpu_en_o,
    output logic                halted_o,
    output logic                done_o,
    output logic [1:0]          halt_cause_o,
    output logic [RETIRE_W-1:0] retire_cnt_o
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_RUN_N  = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_HALT  = 2'd0;
    localparam logic [1:0] c_OP_STEP  = 2'd1;
    localparam logic [1:0] c_OP_RUN   = 2'd2;
    localparam logic [1:0] c_OP_RUN_N = 2'd3;

    localparam logic [1:0] c_CAUSE_HOST  = 2'd0;
    localparam logic [1:0] c_CAUSE_COUNT = 2'd1;
    localparam logic [1:0] c_CAUSE_BP    = 2'd2;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                bp_skip_q, bp_skip_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;
    logic [1:0]          cause_q, cause_d;
    logic                done_q, done_d;

    logic w_running;
    logic w_bp_hit;
    logic w_cpu_en;
    logic w_accept;
    logic w_last_cycle;

    assign w_running    = (state_q != ST_HALTED);
    // bp_skip lets a run resumed on the breakpoint PC execute that instruction once.
    assign w_bp_hit     = w_running & bp_en_i & (pc_i == bp_addr_i) & ~bp_skip_q;
    assign w_cpu_en     = w_running & ~w_bp_hit;
    assign cmd_ready_o  = ~w_running | (cmd_op_i == c_OP_HALT);
    assign w_accept     = cmd_valid_i & cmd_ready_o;
    assign w_last_cycle = (state_q == ST_RUN_N) & w_cpu_en & (remaining_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALTED;
            remaining_q <= '0;
            bp_skip_q   <= 1'b0;
            retire_q    <= '0;
            cause_q     <= c_CAUSE_HOST;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bp_skip_q   <= bp_skip_d;
            retire_q    <= retire_d;
            cause_q     <= cause_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bp_skip_d   = bp_skip_q;
        retire_d    = retire_q;
        cause_d     = cause_q;
        done_d      = 1'b0;

        if (w_cpu_en) begin
            retire_d  = retire_q + RETIRE_W'(1);
            bp_skip_d = 1'b0;
        end

        case (state_q)
            ST_HALTED: begin
                if (w_accept) begin
                    case (cmd_op_i)
                        c_OP_STEP: begin
                            state_d     = ST_RUN_N;
                            remaining_d = CNT_W'(1);
                            bp_skip_d   = 1'b1;
                        end
                        c_OP_RUN: begin
                            state_d   = ST_RUN;
                            bp_skip_d = 1'b1;
                        end
                        c_OP_RUN_N: begin
                            if (cmd_count_i == '0) begin
                                done_d  = 1'b1;
                                cause_d = c_CAUSE_COUNT;
                            end else begin
                                state_d     = ST_RUN_N;
                                remaining_d = cmd_count_i;
                                bp_skip_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if ((state_q == ST_RUN_N) && w_cpu_en) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                // Cause priority when halt events coincide: breakpoint, count, host.
                if (w_bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = c_CAUSE_BP;
                    done_d  = 1'b1;
                end else if (w_last_cycle) begin
                    state_d = ST_HALTED;
                    cause_d = c_CAUSE_COUNT;
                    done_d  = 1'b1;
                end else if (w_accept && (cmd_op_i == c_OP_HALT)) begin
                    state_d = ST_HALTED;
                    cause_d = c_CAUSE_HOST;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    assign cpu_en_o     = w_cpu_en;
    assign halted_o     = ~w_running;
    assign done_o       = done_q;
    assign halt_cause_o = cause_q;
    assign retire_cnt_o = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_controller
// Description : Self-checking bench for cpu_run_controller with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_count = 16'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc;

    logic        cmd_ready, cpu_en, halted, done;
    logic [1:0]  cause;
    logic [31:0] retire;
    logic        cmd_ready4, cpu_en4, halted4, done4;
    logic [1:0]  cause4;
    logic [3:0]  retire4;

    int checks = 0;
    int failures = 0;
    int tot_en = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(.PC_W(32), .CNT_W(16), .RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_count_i(cmd_count),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
        .cpu_en_o(cpu_en), .halted_o(halted), .done_o(done),
        .halt_cause_o(cause), .retire_cnt_o(retire)
    );

    cpu_run_controller #(.PC_W(32), .CNT_W(16), .RETIRE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready4),
        .cmd_op_i(cmd_op), .cmd_count_i(cmd_count),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
        .cpu_en_o(cpu_en4), .halted_o(halted4), .done_o(done4),
        .halt_cause_o(cause4), .retire_cnt_o(retire4)
    );

    // Stand-in processor: each enabled edge retires one 4-byte instruction.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    always @(posedge clk) begin
        if (rst_n && cpu_en) tot_en <= tot_en + 1;
    end

    // Reference model: active flag plus cycles left (-1 = unbounded).
    logic        m_active, m_skip, m_done;
    int          m_left;
    logic [31:0] m_ret;
    logic [1:0]  m_cause;

    function automatic logic m_hit();
        return m_active && bp_en && (pc == bp_addr) && !m_skip;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic       hit, en, stop;
        logic [1:0] c;
        int         left;
        if (!rst_n) begin
            m_active <= 1'b0; m_skip <= 1'b0; m_done <= 1'b0;
            m_left <= 0; m_ret <= 32'd0; m_cause <= 2'd0;
        end else begin
            hit  = m_hit();
            en   = m_active && !hit;
            stop = 1'b0;
            c    = m_cause;
            left = m_left;
            m_done <= 1'b0;
            if (!m_active) begin
                if (cmd_valid) begin
                    if (cmd_op == 2'd1) begin
                        m_active <= 1'b1; m_left <= 1; m_skip <= 1'b1;
                    end else if (cmd_op == 2'd2) begin
                        m_active <= 1'b1; m_left <= -1; m_skip <= 1'b1;
                    end else if (cmd_op == 2'd3) begin
                        if (cmd_count == 16'd0) begin
                            m_done <= 1'b1; m_cause <= 2'd1;
                        end else begin
                            m_active <= 1'b1; m_left <= int'(cmd_count); m_skip <= 1'b1;
                        end
                    end
                end
            end else begin
                if (en) begin
                    m_ret  <= m_ret + 32'd1;
                    m_skip <= 1'b0;
                    if (left > 0) left = left - 1;
                end
                if (hit) begin
                    stop = 1'b1; c = 2'd2;
                end else if (en && left == 0) begin
                    stop = 1'b1; c = 2'd1;
                end else if (cmd_valid && cmd_op == 2'd0) begin
                    stop = 1'b1; c = 2'd0;
                end
                m_left <= left;
                if (stop) begin
                    m_active <= 1'b0; m_cause <= c; m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("cpu_en",    {31'd0, cpu_en},    {31'd0, m_active && !m_hit()});
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_active || cmd_op == 2'd0});
            chk("halted",    {31'd0, halted},    {31'd0, !m_active});
            chk("done",      {31'd0, done},      {31'd0, m_done});
            chk("cause",     {30'd0, cause},     {30'd0, m_cause});
            chk("retire",    retire,             m_ret);
            chk("retire4",   {28'd0, retire4},   {28'd0, m_ret[3:0]});
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] op, input logic [15:0] cnt);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        #1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("send_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
    endtask

    task automatic wait_done();
        int n = 0;
        #1;
        while (!done && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int e;
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (5) @(negedge clk);
        chk("t1_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_retire", retire, 32'd0);
        chk("t1_done",   {31'd0, done}, 32'd0);

        // Three single steps
        e = tot_en;
        for (int i = 0; i < 3; i++) begin
            send(2'd1, 16'd0);
            wait_done();
            chk("t2_cause", {30'd0, cause}, 32'd1);
        end
        chk("t2_retire", retire, 32'd3);
        chk("t2_pc", pc, 32'd12);
        chk("t2_en", tot_en - e, 32'd3);

        // Bounded run of 10
        e = tot_en;
        send(2'd3, 16'd10);
        wait_done();
        chk("t3_en", tot_en - e, 32'd10);
        chk("t3_retire", retire, 32'd13);
        chk("t3_cause", {30'd0, cause}, 32'd1);

        // Breakpoint on the 4th instruction from here (pc 52 -> bp 64)
        bp_en = 1'b1; bp_addr = 32'd64;
        send(2'd2, 16'd0);
        wait_done();
        chk("t4_retire", retire, 32'd16);
        chk("t4_cause", {30'd0, cause}, 32'd2);
        chk("t4_pc", pc, 32'd64);
        send(2'd1, 16'd0);
        wait_done();
        chk("t4_step_retire", retire, 32'd17);
        chk("t4_step_pc", pc, 32'd68);
        chk("t4_step_cause", {30'd0, cause}, 32'd1);
        bp_en = 1'b0;

        // Unbounded run halted by host after 7 enabled cycles
        e = tot_en;
        send(2'd2, 16'd0);
        n = 0;
        while (tot_en - e < 7 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t5_run7", tot_en - e, 32'd7);
        send(2'd0, 16'd0);
        wait_done();
        chk("t5_en", tot_en - e, 32'd8);
        chk("t5_retire", retire, 32'd25);
        chk("t5_cause", {30'd0, cause}, 32'd0);

        // RUN_N with zero count
        e = tot_en;
        send(2'd3, 16'd0);
        wait_done();
        chk("t3z_en", tot_en - e, 32'd0);
        chk("t3z_cause", {30'd0, cause}, 32'd1);

        // RUN_N 5 with HALT landing on the final edge
        e = tot_en;
        send(2'd3, 16'd5);
        repeat (4) @(negedge clk);
        send(2'd0, 16'd0);
        wait_done();
        chk("t5n_en", tot_en - e, 32'd5);
        chk("t5n_retire", retire, 32'd30);
        chk("t5n_cause", {30'd0, cause}, 32'd1);

        // HALT while halted is a no-op
        send(2'd0, 16'd0);
        repeat (3) @(negedge clk);
        chk("t5h_halted", {31'd0, halted}, 32'd1);
        chk("t5h_cause", {30'd0, cause}, 32'd1);

        // Asynchronous reset in the middle of RUN_N 20
        send(2'd3, 16'd20);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_retire", retire, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_cause", {30'd0, cause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 17 retirements wrap the 4-bit counter to 1
        send(2'd3, 16'd17);
        wait_done();
        chk("t6_retire17", retire, 32'd17);
        chk("t6_wrap", {28'd0, retire4}, 32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
